// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage with valid/ready handshake, stall, flush and illegal flagging
module decode_stage #(
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [PC_WIDTH-1:0] in_pc,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [6:0]          out_opcode,
    output logic [2:0]          out_funct3,
    output logic [6:0]          out_funct7,
    output logic [4:0]          out_rd,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [31:0]         out_imm,
    output logic                out_alu_src_imm,
    output logic                out_reg_write,
    output logic                out_mem_read,
    output logic                out_mem_write,
    output logic                out_branch,
    output logic                out_illegal
);
    localparam logic [6:0] OP_REG_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG_REG = 7'b0110011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic        is_ri, is_rr, is_ld, is_st, is_br, ill;
    logic [4:0]  rd_d, rs2_d;
    logic [31:0] imm_d;
    logic        cap;
    assign op    = in_instr[6:0];
    assign f3    = in_instr[14:12];
    assign f7    = in_instr[31:25];
    assign is_ri = op == OP_REG_IMM;
    assign is_rr = op == OP_REG_REG;
    assign is_ld = op == OP_LOAD;
    assign is_st = op == OP_STORE;
    assign is_br = op == OP_BRANCH;
    always_comb begin
        ill = !(is_ri || is_rr || is_ld || is_st || is_br)
            || (is_rr && f7 != 7'h00 && f7 != 7'h20)
            || (is_rr && f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101)
            || (is_ri && f3 == 3'b001 && f7 != 7'h00)
            || (is_ri && f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20)
            || (is_ld && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111))
            || (is_st && f3 >= 3'b011)
            || (is_br && (f3 == 3'b010 || f3 == 3'b011));
        imm_d = (is_ri || is_ld) ? {{20{in_instr[31]}}, in_instr[31:20]}
              : is_st ? {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]}
              : is_br ? {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}
              : 32'd0;
        rd_d  = (is_st || is_br) ? 5'd0 : in_instr[11:7];
        rs2_d = (is_rr || is_st || is_br) ? in_instr[24:20] : 5'd0;
    end
    assign in_ready = !out_valid || out_ready;
    assign cap      = in_valid && in_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid       <= 1'b0;
            out_pc          <= '0;
            out_opcode      <= '0;
            out_funct3      <= '0;
            out_funct7      <= '0;
            out_rd          <= '0;
            out_rs1         <= '0;
            out_rs2         <= '0;
            out_imm         <= '0;
            out_alu_src_imm <= 1'b0;
            out_reg_write   <= 1'b0;
            out_mem_read    <= 1'b0;
            out_mem_write   <= 1'b0;
            out_branch      <= 1'b0;
            out_illegal     <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (cap) begin
            out_valid       <= 1'b1;
            out_pc          <= in_pc;
            out_opcode      <= op;
            out_funct3      <= f3;
            out_funct7      <= is_rr ? f7 : 7'd0;
            out_rd          <= rd_d;
            out_rs1         <= in_instr[19:15];
            out_rs2         <= rs2_d;
            out_imm         <= imm_d;
            out_alu_src_imm <= is_ri || is_ld || is_st;
            out_reg_write   <= !ill && (is_ri || is_rr || is_ld) && rd_d != 5'd0;
            out_mem_read    <= !ill && is_ld;
            out_mem_write   <= !ill && is_st;
            out_branch      <= !ill && is_br;
            out_illegal     <= ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
